// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
//   Bundles the signals around the shared data memory. There are three groups:
//   the CPU (MEM stage) port, the DMA/loader port, and the memory-side port.
//   slave  : the arbiter's view. It takes requests and mem_rdata, and drives
//            grants, stall, read data and the memory controls.
//   master : the surrounding system's view, which is the opposite direction.
//
//   Handshakes:
//     CPU: an access completes in a cycle where cpu_req=1 and cpu_stall=0.
//          While cpu_stall=1, the pipeline keeps cpu_req, cpu_we, cpu_addr
//          and cpu_wdata stable.
//     DMA: a beat completes in a cycle where dma_req=1 and dma_gnt=1.
//          dma_req, dma_we, dma_addr and dma_wdata stay stable until then.
//          For a read beat, dma_rvalid is high for exactly one cycle, in the
//          cycle after the grant, and dma_rdata is valid in that cycle.
interface dmem_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [DATA_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              dma_req;
  logic              dma_we;
  logic [DATA_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_rvalid;

  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_rdata, dma_rvalid,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_rdata, dma_rvalid,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares a single-port data memory between the pipeline MEM stage (CPU)
//   and a DMA/loader port. The CPU wins by default. A DMA request that keeps
//   losing to the CPU for STARVE_LIMIT consecutive cycles takes ownership of
//   the memory (S_DMA). It then keeps ownership for up to MAX_BURST beats,
//   or until it drops dma_req.
// Ports
//   clk       : rising-edge clock
//   reset     : asynchronous, active-high
//   bus       : dmem_arbiter_if.slave (CPU, DMA and memory-side signals)
//   dbg_state : current arbitration state (0 = S_CPU, 1 = S_DMA)
module dmem_arbiter #(
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_BURST    = 4
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus,
  output logic           dbg_state
);

  localparam int WAIT_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
  localparam int BEAT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT - 1);
  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(MAX_BURST - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);
  localparam logic [BEAT_W-1:0] BEAT_ONE = BEAT_W'(1);

  typedef enum logic {
    S_CPU = 1'b0,
    S_DMA = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic              dma_rvalid_q, dma_rvalid_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;

  logic cpu_gnt;
  logic dma_gnt;
  logic denial;

  // Grants are combinational, so they are masked while reset is high. This
  // keeps a write that was in progress from reaching the memory.
  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (!reset) begin
      if (state_q == S_CPU) begin
        cpu_gnt = bus.cpu_req;
        dma_gnt = bus.dma_req & ~bus.cpu_req;
      end else begin
        dma_gnt = bus.dma_req;
      end
    end
    denial = (state_q == S_CPU) & bus.cpu_req & bus.dma_req;
  end

  // Memory-side mux. When nothing is granted, all controls are driven to zero.
  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (cpu_gnt) begin
      bus.mem_we    = bus.cpu_we;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
    end else if (dma_gnt) begin
      bus.mem_we    = bus.dma_we;
      bus.mem_addr  = bus.dma_addr;
      bus.mem_wdata = bus.dma_wdata;
    end
  end

  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.cpu_stall  = ~reset & bus.cpu_req & ~cpu_gnt;
  assign bus.dma_gnt    = dma_gnt;
  assign bus.dma_rdata  = dma_rdata_q;
  assign bus.dma_rvalid = dma_rvalid_q;
  assign dbg_state      = state_q;

  // Next-state and counter logic.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    beat_cnt_d = beat_cnt_q;
    if (state_q == S_CPU) begin
      beat_cnt_d = '0;
      // Any cycle that is not a denial clears wait_cnt. That covers both
      // "DMA not requesting" and "DMA granted". It also covers dma_req
      // falling in the same cycle that would otherwise have caused a
      // takeover.
      if (denial) begin
        if (wait_cnt_q == WAIT_MAX) begin
          state_d = S_DMA;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_ONE;
        end
      end
    end else begin
      if (!bus.dma_req) begin
        state_d    = S_CPU;
        beat_cnt_d = '0;
      end else if (beat_cnt_q == BEAT_MAX) begin
        state_d    = S_CPU;
        beat_cnt_d = '0;
      end else begin
        beat_cnt_d = beat_cnt_q + BEAT_ONE;
      end
    end
  end

  // DMA read return. The data is captured on the edge that ends the granted
  // read beat. dma_rdata holds its value between reads.
  always_comb begin
    dma_rvalid_d = 1'b0;
    dma_rdata_d  = dma_rdata_q;
    if (dma_gnt && !bus.dma_we) begin
      dma_rvalid_d = 1'b1;
      dma_rdata_d  = bus.mem_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_CPU;
      wait_cnt_q   <= '0;
      beat_cnt_q   <= '0;
      dma_rvalid_q <= 1'b0;
      dma_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
      dma_rvalid_q <= dma_rvalid_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Directed bench for dmem_arbiter. It drives a table of per-cycle vectors
//   into the default-parameter instance, with a behavioural memory attached.
//   It then runs hand-written sequences for reset in the middle of a burst
//   and for a STARVE_LIMIT=1 instance.
module tb_dmem_arbiter;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  localparam logic [31:0] Z = 32'h0;
  localparam logic [31:0] R = 32'h1234_5678;
  localparam logic [31:0] D = 32'hDEAD_BEEF;

  logic clk;
  logic reset;
  logic dbg_state;
  logic dbg_state1;

  int checks = 0;
  int errors = 0;

  dmem_arbiter_if #(.DATA_W(32)) bus ();
  dmem_arbiter_if #(.DATA_W(32)) bus1 ();

  dmem_arbiter #(.DATA_W(32), .STARVE_LIMIT(4), .MAX_BURST(4)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  dmem_arbiter #(.DATA_W(32), .STARVE_LIMIT(1), .MAX_BURST(2)) u_dut1 (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus1),
    .dbg_state (dbg_state1)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- data memory: combinational read, clocked write --------
  logic [31:0] mem [0:255];
  initial for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  assign bus.mem_rdata  = mem[bus.mem_addr[9:2]];
  assign bus1.mem_rdata = 32'h0;
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;

  // ---------------- vectors ----------------
  typedef struct {
    logic        cr, cw;
    logic [31:0] ca, cd;
    logic        dr, dw;
    logic [31:0] da, dd;
    logic        e_stall, e_gnt, e_we;
    logic [31:0] e_addr;
    logic        e_state, e_rvalid;
    logic [31:0] e_rdata;
    logic        chk_crd;
    logic [31:0] e_crd;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t v(
    input logic cr, cw, input logic [31:0] ca, cd,
    input logic dr, dw, input logic [31:0] da, dd,
    input logic es, eg, ew, input logic [31:0] ea,
    input logic est, erv, input logic [31:0] erd,
    input logic cc, input logic [31:0] ecrd);
    vec_t r;
    r.cr = cr; r.cw = cw; r.ca = ca; r.cd = cd;
    r.dr = dr; r.dw = dw; r.da = da; r.dd = dd;
    r.e_stall = es; r.e_gnt = eg; r.e_we = ew; r.e_addr = ea;
    r.e_state = est; r.e_rvalid = erv; r.e_rdata = erd;
    r.chk_crd = cc; r.e_crd = ecrd;
    return r;
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic drive(input logic cr, cw, input logic [31:0] ca, cd,
                       input logic dr, dw, input logic [31:0] da, dd);
    bus.cpu_req = cr; bus.cpu_we = cw; bus.cpu_addr = ca; bus.cpu_wdata = cd;
    bus.dma_req = dr; bus.dma_we = dw; bus.dma_addr = da; bus.dma_wdata = dd;
  endtask

  task automatic drive1(input logic cr, input logic dr);
    bus1.cpu_req = cr; bus1.cpu_we = L; bus1.cpu_addr = 32'h40; bus1.cpu_wdata = Z;
    bus1.dma_req = dr; bus1.dma_we = L; bus1.dma_addr = 32'h80; bus1.dma_wdata = Z;
  endtask

  task automatic build_vectors();
    // CPU only: store then load
    vq.push_back(v(H,H,32'h10,D, L,L,Z,Z, L,L,H,32'h10, L,L,Z, L,Z));
    vq.push_back(v(H,L,32'h10,Z, L,L,Z,Z, L,L,L,32'h10, L,L,Z, H,D));
    vq.push_back(v(L,L,Z,Z,      L,L,Z,Z, L,L,L,Z,      L,L,Z, L,Z));
    // DMA only: three single-beat writes, state stays S_CPU
    vq.push_back(v(L,L,Z,Z, H,H,32'h100,32'hA0, L,H,H,32'h100, L,L,Z, L,Z));
    vq.push_back(v(L,L,Z,Z, H,H,32'h104,32'hA1, L,H,H,32'h104, L,L,Z, L,Z));
    vq.push_back(v(L,L,Z,Z, H,H,32'h108,32'hA2, L,H,H,32'h108, L,L,Z, L,Z));
    vq.push_back(v(H,L,32'h104,Z, L,L,Z,Z, L,L,L,32'h104, L,L,Z, H,32'hA1));
    vq.push_back(v(H,L,32'h108,Z, L,L,Z,Z, L,L,L,32'h108, L,L,Z, H,32'hA2));
    // CPU store 0x20, then DMA read returns it one cycle later for one cycle
    vq.push_back(v(H,H,32'h20,R, L,L,Z,Z,     L,L,H,32'h20, L,L,Z, L,Z));
    vq.push_back(v(L,L,Z,Z,      H,L,32'h20,Z, L,H,L,32'h20, L,L,Z, L,Z));
    vq.push_back(v(L,L,Z,Z,      L,L,Z,Z,      L,L,L,Z,      L,H,R, L,Z));
    vq.push_back(v(L,L,Z,Z,      L,L,Z,Z,      L,L,L,Z,      L,L,R, L,Z));
    // Contention: CPU x4, DMA burst x4 with stall, CPU again
    for (int i = 0; i < 4; i++)
      vq.push_back(v(H,L,32'h10,Z, H,H,32'h200,32'hB0, L,L,L,32'h10, L,L,R, H,D));
    for (int i = 0; i < 4; i++)
      vq.push_back(v(H,L,32'h10,Z, H,H,32'h200,32'hB0, H,H,H,32'h200, H,L,R, L,Z));
    for (int i = 0; i < 4; i++)
      vq.push_back(v(H,L,32'h10,Z, H,H,32'h200,32'hB0, L,L,L,32'h10, L,L,R, H,D));
    // Second takeover, DMA drops after two beats
    for (int i = 0; i < 2; i++)
      vq.push_back(v(H,L,32'h10,Z, H,H,32'h200,32'hB0, H,H,H,32'h200, H,L,R, L,Z));
    vq.push_back(v(H,L,32'h10,Z, L,L,Z,Z, H,L,L,Z,       H,L,R, L,Z));
    vq.push_back(v(H,L,32'h10,Z, L,L,Z,Z, L,L,L,32'h10, L,L,R, H,D));
    // Three denials, then dma_req falls at the would-be takeover: counter clears
    for (int i = 0; i < 3; i++)
      vq.push_back(v(H,L,32'h10,Z, H,H,32'h200,32'hB0, L,L,L,32'h10, L,L,R, L,Z));
    vq.push_back(v(H,L,32'h10,Z, L,L,Z,Z, L,L,L,32'h10, L,L,R, L,Z));
    for (int i = 0; i < 2; i++)
      vq.push_back(v(H,L,32'h10,Z, H,H,32'h200,32'hB0, L,L,L,32'h10, L,L,R, L,Z));
    vq.push_back(v(L,L,Z,Z, L,L,Z,Z, L,L,L,Z, L,L,R, L,Z));
    vq.push_back(v(L,L,Z,Z, L,L,Z,Z, L,L,L,Z, L,L,R, L,Z));
  endtask

  // ---------------- test ----------------
  initial begin
    reset = H;
    drive(L,L,Z,Z, L,L,Z,Z);
    drive1(L,L);
    build_vectors();

    // Reset state, with requests asserted while reset is held
    @(negedge clk);
    drive(H,H,32'h10,D, H,H,32'h100,32'h55);
    #2;
    chk("rst_stall",  bus.cpu_stall,  L);
    chk("rst_gnt",    bus.dma_gnt,    L);
    chk("rst_we",     bus.mem_we,     L);
    chk("rst_state",  dbg_state,      L);
    chk("rst_rvalid", bus.dma_rvalid, L);
    chk("rst_rdata",  bus.dma_rdata,  Z);
    @(negedge clk);
    drive(L,L,Z,Z, L,L,Z,Z);
    reset = L;

    // Table-driven vectors: drive at negedge, compare 2 ns later
    for (int i = 0; i < vq.size(); i++) begin
      if (i != 0) @(negedge clk);
      drive(vq[i].cr, vq[i].cw, vq[i].ca, vq[i].cd, vq[i].dr, vq[i].dw, vq[i].da, vq[i].dd);
      #2;
      chk($sformatf("v%0d_stall", i),  bus.cpu_stall,  vq[i].e_stall);
      chk($sformatf("v%0d_gnt", i),    bus.dma_gnt,    vq[i].e_gnt);
      chk($sformatf("v%0d_we", i),     bus.mem_we,     vq[i].e_we);
      chk($sformatf("v%0d_addr", i),   bus.mem_addr,   vq[i].e_addr);
      chk($sformatf("v%0d_state", i),  dbg_state,      vq[i].e_state);
      chk($sformatf("v%0d_rvalid", i), bus.dma_rvalid, vq[i].e_rvalid);
      chk($sformatf("v%0d_rdata", i),  bus.dma_rdata,  vq[i].e_rdata);
      if (vq[i].chk_crd) chk($sformatf("v%0d_cpu_rdata", i), bus.cpu_rdata, vq[i].e_crd);
    end

    // Reset in the middle of a burst: four CPU cycles, then DMA read beats 0 and 1
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(H,L,32'h10,Z, H,L,32'h300,Z);
    end
    #2;
    chk("mb_state_beat1", dbg_state, H);
    @(negedge clk);
    drive(H,L,32'h10,Z, H,H,32'h300,32'hCC);   // beat 2 is a write
    #2;
    chk("mb_we_pre",     bus.mem_we,     H);
    chk("mb_rvalid_pre", bus.dma_rvalid, H);
    reset = H;
    #1;
    chk("mb_we",     bus.mem_we,     L);
    chk("mb_gnt",    bus.dma_gnt,    L);
    chk("mb_stall",  bus.cpu_stall,  L);
    chk("mb_state",  dbg_state,      L);
    chk("mb_rvalid", bus.dma_rvalid, L);
    chk("mb_rdata",  bus.dma_rdata,  Z);
    @(negedge clk);
    chk("mb_no_write", mem[8'hC0], Z);
    reset = L;
    #2;
    chk("mb_rel_stall", bus.cpu_stall, L);
    chk("mb_rel_addr",  bus.mem_addr,  32'h10);
    chk("mb_rel_state", dbg_state,     L);
    @(negedge clk);
    drive(L,L,Z,Z, L,L,Z,Z);

    // STARVE_LIMIT=1, MAX_BURST=2: one denial, then a two-beat burst
    @(negedge clk);
    drive1(H,H);
    #2;
    chk("sl1_c0_state", dbg_state1,     L);
    chk("sl1_c0_stall", bus1.cpu_stall, L);
    chk("sl1_c0_gnt",   bus1.dma_gnt,   L);
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      #2;
      chk($sformatf("sl1_c%0d_state", i), dbg_state1,     H);
      chk($sformatf("sl1_c%0d_stall", i), bus1.cpu_stall, H);
      chk($sformatf("sl1_c%0d_gnt", i),   bus1.dma_gnt,   H);
      chk($sformatf("sl1_c%0d_addr", i),  bus1.mem_addr,  32'h80);
    end
    @(negedge clk);
    #2;
    chk("sl1_c3_state", dbg_state1,     L);
    chk("sl1_c3_stall", bus1.cpu_stall, L);
    chk("sl1_c3_gnt",   bus1.dma_gnt,   L);
    chk("sl1_c3_addr",  bus1.mem_addr,  32'h40);
    @(negedge clk);
    drive1(L,L);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
